mem_port_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/mem_port_arbiter_pick.sv | 29 ++
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and latency helpers for the memory port arbiter.
// Used by mem_port_arbiter and arb_pick (optional macro: ARB_ROUND_ROBIN_EN).
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_VGA  = 2'b10
    } owner_e;

    localparam int unsigned MEM_LAT_MIN = 1;
    localparam int unsigned MEM_LAT_MAX = 15;
    localparam int unsigned CNT_W       = 4;

    // Out-of-range latencies saturate to the longest wait the counter can hold.
    function automatic logic [CNT_W-1:0] lat_load(input int unsigned lat);
        if (lat < MEM_LAT_MIN || lat > MEM_LAT_MAX) begin
            return '1;
        end
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between CPU and VGA requests.
// ARB_ROUND_ROBIN_EN: alternate on contention using the last-grant input.
module arb_pick
    import mem_arb_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   vga_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic   last_vga_i,
`endif
    output owner_e grant_o
);

    always_comb begin
        grant_o = OWN_NONE;
        if (cpu_req_i && vga_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            grant_o = last_vga_i ? OWN_CPU : OWN_VGA;
`else
            grant_o = OWN_VGA;
`endif
        end else if (vga_req_i) begin
            grant_o = OWN_VGA;
        end else if (cpu_req_i) begin
            grant_o = OWN_CPU;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between the CPU bus and the VGA fetch unit.
// ARB_ROUND_ROBIN_EN selects round-robin arbitration instead of VGA priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_rdata,
    output logic              vga_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner,
    output logic [1:0]        state_out
);

    localparam logic [CNT_W-1:0] LAT_LOAD = lat_load(MEM_LAT);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            grant;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
    logic              owner_is_cpu;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_vga_q, last_vga_d;
`endif

    arb_pick u_pick (
        .cpu_req_i  (cpu_req),
        .vga_req_i  (vga_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_vga_i (last_vga_q),
`endif
        .grant_o    (grant)
    );

    assign owner_is_cpu = (owner_q == OWN_CPU);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_NONE;
            cnt_q       <= '0;
            cpu_rdata_q <= '0;
            vga_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_rdata_q <= vga_rdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Reset value "CPU last" makes the first contended grant go to VGA.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_vga_q <= 1'b0;
        end else begin
            last_vga_q <= last_vga_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        vga_rdata_d = vga_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_vga_d  = last_vga_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (grant != OWN_NONE) begin
                    owner_d = grant;
                    state_d = ST_ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_vga_d = (grant == OWN_VGA);
`endif
                end
            end
            ST_ISSUE: begin
                if (owner_is_cpu && cpu_we) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_LOAD;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_is_cpu) begin
                        cpu_rdata_d = mem_rdata;
                    end else begin
                        vga_rdata_d = mem_rdata;
                    end
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                owner_d = OWN_NONE;
                state_d = ST_IDLE;
            end
            default: begin
                owner_d = OWN_NONE;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        cpu_ready = 1'b0;
        vga_ready = 1'b0;
        mem_addr  = owner_is_cpu ? cpu_addr : vga_addr;
        mem_wdata = owner_is_cpu ? cpu_wdata : '0;
        unique case (state_q)
            ST_ISSUE: begin
                mem_en = 1'b1;
                mem_we = owner_is_cpu && cpu_we;
            end
            ST_DONE: begin
                cpu_ready = (owner_q == OWN_CPU);
                vga_ready = (owner_q == OWN_VGA);
            end
            default: begin
            end
        endcase
    end

    assign cpu_rdata = cpu_rdata_q;
    assign vga_rdata = vga_rdata_q;
    assign owner     = owner_q;
    assign state_out = state_q;

endmodule
